// File: rtl/stopwatch_control.sv
// Stopwatch front end: button conditioning, mode FSM and tenth-second tick prescaler.
// Optional lap/display-hold feature is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_control #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned TICK_HZ         = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_n,
  input  logic       btn_pause_n,
  input  logic       btn_stop_n,
  input  logic       btn_reset_n,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap_n,
  output logic       display_hold,
`endif
  input  logic       wrap_i,
  output logic       count_en,
  output logic       count_clr,
  output logic       tick,
  output logic [1:0] state
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW       = $clog2(TICK_DIV);
  localparam int unsigned DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef STOPWATCH_LAP_EN
  localparam int unsigned NB = 5;
`else
  localparam int unsigned NB = 4;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    STOPPED = 2'b11
  } state_t;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] db_lvl_q, db_lvl_d;
  logic [NB-1:0] press_q, press_d;
  logic [DW-1:0] db_cnt_q [NB];
  logic [DW-1:0] db_cnt_d [NB];

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          count_en_q, count_en_d;
  logic          count_clr_q, count_clr_d;
  logic          tick_q, tick_d;
  logic          p_start, p_pause, p_stop, p_reset;
  logic          enter_stopped;

  always_comb begin
`ifdef STOPWATCH_LAP_EN
    btn_raw = {btn_lap_n, btn_reset_n, btn_stop_n, btn_pause_n, btn_start_n};
`else
    btn_raw = {btn_reset_n, btn_stop_n, btn_pause_n, btn_start_n};
`endif
  end

  // Press pulse is registered on the same edge the debounced level falls.
  always_comb begin
    db_lvl_d = db_lvl_q;
    press_d  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl_d[i] = sync2_q[i];
          press_d[i]  = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    p_start = press_q[0];
    p_pause = press_q[1];
    p_stop  = press_q[2];
    p_reset = press_q[3];
  end

  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;
    if (p_reset) begin
      state_d     = IDLE;
      count_clr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE:    if (p_start) state_d = RUNNING;
        RUNNING: begin
          if (p_stop || wrap_i) state_d = STOPPED;
          else if (p_pause)     state_d = PAUSED;
        end
        PAUSED: begin
          if (p_stop)       state_d = STOPPED;
          else if (p_start) state_d = RUNNING;
        end
        default: state_d = state_q;
      endcase
    end

    enter_stopped = (state_d == STOPPED) && (state_q != STOPPED);

    // Advance on edges leaving a RUNNING cycle, so a pause keeps the partial interval.
    presc_d = presc_q;
    if (count_clr_d || enter_stopped) begin
      presc_d = '0;
    end else if (state_q == RUNNING) begin
      presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + 1'b1;
    end

    tick_d     = (state_d == RUNNING) && (presc_d == PW'(TICK_DIV - 1));
    count_en_d = (state_d == RUNNING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      db_lvl_q    <= '1;
      press_q     <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt_q[i] <= '0;
      state_q     <= IDLE;
      presc_q     <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      db_lvl_q    <= db_lvl_d;
      press_q     <= press_d;
      for (int unsigned i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q     <= state_d;
      presc_q     <= presc_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      tick_q      <= tick_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (p_reset || enter_stopped) begin
      hold_d = 1'b0;
    end else if (press_q[4]) begin
      if (state_q == RUNNING)     hold_d = ~hold_q;
      else if (state_q == PAUSED) hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 1'b0;
    else        hold_q <= hold_d;
  end

  assign display_hold = hold_q;
`endif

  assign count_en  = count_en_q;
  assign count_clr = count_clr_q;
  assign tick      = tick_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed self-checking bench for stopwatch_control (TICK_DIV=10, DEBOUNCE_CYCLES=4).
module tb_stopwatch_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start_n, btn_pause_n, btn_stop_n, btn_reset_n;
  logic       wrap_i;
  logic       count_en, count_clr, tick;
  logic [1:0] state;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned tick_cnt = 0;
  int unsigned paused_cyc = 0;
  int unsigned viol = 0;
  int unsigned n;
  int unsigned snap;

  stopwatch_control #(
    .CLK_HZ          (100),
    .TICK_HZ         (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start_n (btn_start_n),
    .btn_pause_n (btn_pause_n),
    .btn_stop_n  (btn_stop_n),
    .btn_reset_n (btn_reset_n),
    .wrap_i      (wrap_i),
    .count_en    (count_en),
    .count_clr   (count_clr),
    .tick        (tick),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Invariants: tick only in RUNNING, never with count_clr; count_en mirrors RUNNING.
  always @(negedge clk) begin
    if (tick) tick_cnt <= tick_cnt + 1;
    if (state == 2'b10) paused_cyc <= paused_cyc + 1;
    if (rst_n && ((tick && state != 2'b01) || (tick && count_clr) ||
                  (count_en != (state == 2'b01))))
      viol <= viol + 1;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] exp, input int unsigned budget,
                            output int unsigned cnt);
    cnt = 0;
    while (state !== exp && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Counts the current cycle as 1.
  task automatic wait_tick(input int unsigned budget, output int unsigned cnt);
    cnt = 1;
    while (tick !== 1'b1 && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_start_n = 1'b1; btn_pause_n = 1'b1; btn_stop_n = 1'b1; btn_reset_n = 1'b1;
    wrap_i = 1'b0;
    step(3);
    check("rst_state", state, 0);
    check("rst_count_en", count_en, 0);
    check("rst_count_clr", count_clr, 0);
    check("rst_tick", tick, 0);
    rst_n = 1'b1;
    step(2);

    // Bounce start: never stable for 4 cycles.
    for (int i = 0; i < 10; i++) begin
      btn_start_n = (i % 2 == 1);
      step(2);
    end
    check("bounce_idle", state, 0);
    btn_start_n = 1'b0;
    wait_state(2'b01, 40, n);
    check("start_latency", n, 7);
    check("start_state", state, 1);
    check("start_count_en", count_en, 1);
    wait_tick(40, n);
    check("first_tick", n, 10);
    btn_start_n = 1'b1;
    step(1);
    wait_tick(40, n);
    check("tick_period", n, 10);

    // Pause press lands with prescaler at 6.
    step(1);
    btn_pause_n = 1'b0;
    wait_state(2'b10, 40, n);
    check("pause_latency", n, 7);
    snap = tick_cnt;
    btn_pause_n = 1'b1;
    step(50);
    check("paused_no_tick", tick_cnt - snap, 0);
    check("paused_state", state, 2);
    btn_start_n = 1'b0;
    wait_state(2'b01, 40, n);
    check("resume_latency", n, 7);
    wait_tick(40, n);
    check("resume_tick", n, 3);
    btn_start_n = 1'b1;
    step(5);

    // Counter wrap stops the watch.
    wrap_i = 1'b1;
    step(1);
    wrap_i = 1'b0;
    check("wrap_state", state, 3);
    check("wrap_count_en", count_en, 0);
    snap = tick_cnt;
    btn_start_n = 1'b0; step(8); btn_start_n = 1'b1; step(10);
    btn_pause_n = 1'b0; step(8); btn_pause_n = 1'b1; step(10);
    btn_stop_n  = 1'b0; step(8); btn_stop_n  = 1'b1; step(10);
    check("stopped_hold", state, 3);
    check("stopped_no_tick", tick_cnt - snap, 0);

    // Reset press clears back to IDLE.
    btn_reset_n = 1'b0;
    wait_state(2'b00, 40, n);
    check("clr_latency", n, 7);
    check("clr_pulse", count_clr, 1);
    step(1);
    check("clr_one_cycle", count_clr, 0);
    btn_reset_n = 1'b1;
    step(10);
    check("clr_stays", count_clr, 0);
    btn_start_n = 1'b0;
    wait_state(2'b01, 40, n);
    check("restart_latency", n, 7);
    wait_tick(40, n);
    check("restart_tick", n, 10);
    btn_start_n = 1'b1;
    step(12);

    // Pause and stop together: stop wins.
    snap = paused_cyc;
    btn_pause_n = 1'b0;
    btn_stop_n  = 1'b0;
    wait_state(2'b11, 40, n);
    check("prio_latency", n, 7);
    step(5);
    check("prio_state", state, 3);
    check("prio_never_paused", paused_cyc - snap, 0);
    btn_pause_n = 1'b1;
    btn_stop_n  = 1'b1;
    step(10);

    btn_reset_n = 1'b0; step(8); btn_reset_n = 1'b1; step(10);
    check("idle_again", state, 0);
    btn_start_n = 1'b0;
    wait_state(2'b01, 40, n);
    check("run_again", state, 1);
    step(7);

    // Async reset while start is held.
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_count_en", count_en, 0);
    check("arst_tick", tick, 0);
    check("arst_count_clr", count_clr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_state(2'b01, 40, n);
    check("arst_press_latency", n, 7);
    check("arst_run", state, 1);
    btn_start_n = 1'b1;
    step(10);

    check("invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
